// File: rtl/uart_alu_sequencer.sv
// Byte-serial ALU transaction sequencer: collects A, B and opcode from the UART receiver,
// presents them to a combinational ALU and launches transmission of the result.
module uart_alu_sequencer #(
    parameter int DBIT    = 8,
    parameter int NB_OP   = 6,
    parameter int TIMEOUT = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_done_tick,
    input  logic [DBIT-1:0]  rx_data,
    input  logic [DBIT-1:0]  alu_result,
    input  logic             tx_done_tick,
    output logic [DBIT-1:0]  alu_a,
    output logic [DBIT-1:0]  alu_b,
    output logic [NB_OP-1:0] alu_op,
    output logic             tx_start,
    output logic [DBIT-1:0]  tx_data,
    output logic             busy,
    output logic             op_done,
    output logic             timeout_err,
    output logic             rx_overrun,
    output logic [4:0]       state
);

    typedef enum logic [4:0] {
        WAIT_A  = 5'b00001,
        WAIT_B  = 5'b00010,
        WAIT_OP = 5'b00100,
        SEND    = 5'b01000,
        WAIT_TX = 5'b10000
    } state_e;

    // A zero TIMEOUT still needs a legal one-bit timer; it simply never counts.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    state_e            state_q;
    logic [TW-1:0]     timer_q;
    logic [DBIT-1:0]   alu_a_q;
    logic [DBIT-1:0]   alu_b_q;
    logic [NB_OP-1:0]  alu_op_q;
    logic [DBIT-1:0]   tx_data_q;
    logic              tx_start_q;
    logic              op_done_q;
    logic              timeout_err_q;
    logic              rx_overrun_q;

    logic timer_expired;
    assign timer_expired = (TIMEOUT != 0) && (timer_q == TIMER_LAST);

    // NOTE: all state updates use non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order inside this block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= WAIT_A;
            timer_q       <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= '0;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            op_done_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            rx_overrun_q  <= 1'b0;
        end else begin
            tx_start_q    <= 1'b0;
            op_done_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            case (state_q)
                WAIT_A: begin
                    timer_q <= '0;
                    if (rx_done_tick) begin
                        alu_a_q <= rx_data;
                        state_q <= WAIT_B;
                    end
                end
                WAIT_B, WAIT_OP: begin
                    // A byte landing in the expiry cycle wins over the timeout.
                    if (rx_done_tick) begin
                        timer_q <= '0;
                        if (state_q == WAIT_B) begin
                            alu_b_q <= rx_data;
                            state_q <= WAIT_OP;
                        end else begin
                            alu_op_q <= rx_data[NB_OP-1:0];
                            state_q  <= SEND;
                        end
                    end else if (timer_expired) begin
                        timer_q       <= '0;
                        timeout_err_q <= 1'b1;
                        state_q       <= WAIT_A;
                    end else if (TIMEOUT != 0) begin
                        timer_q <= timer_q + TIMER_ONE;
                    end
                end
                SEND: begin
                    tx_data_q  <= alu_result;
                    tx_start_q <= 1'b1;
                    timer_q    <= '0;
                    state_q    <= WAIT_TX;
                    if (rx_done_tick) begin
                        rx_overrun_q <= 1'b1;
                    end
                end
                WAIT_TX: begin
                    if (rx_done_tick) begin
                        rx_overrun_q <= 1'b1;
                    end
                    if (tx_done_tick) begin
                        op_done_q <= 1'b1;
                        state_q   <= WAIT_A;
                    end
                end
                default: begin
                    timer_q <= '0;
                    state_q <= WAIT_A;
                end
            endcase
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign op_done     = op_done_q;
    assign timeout_err = timeout_err_q;
    assign rx_overrun  = rx_overrun_q;
    assign state       = state_q;
    assign busy        = (state_q != WAIT_A);

endmodule
